pattern_gen_param: RTL and testbench

PATTERN_GEN_PARAM -- requirements
Module: pattern_gen_param

---
 rtl/pattern_gen_param_pkg.sv | 35 +++
 rtl/pattern_gen_param_vga_timing.sv | 94 +++++++++
 rtl/pattern_gen_param.sv | 183 ++++++++++++++++++
 tb/tb_pattern_gen_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_param_pkg.sv
// Shared definitions for the pattern generator.
// Holds the pattern mode encodings, the default 640x480@60 timing and
// helper functions used by the timing block and the top level.
package pattern_gen_param_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    localparam int DEF_COLOR_W   = 4;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CELL_LOG2 = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Colour-bar index 0..7 -> {R,G,B} on/off, in the order
    // white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return {~idx[1], ~idx[2], ~idx[0]};
    endfunction

endpackage

// File: rtl/pattern_gen_param_vga_timing.sv
// vga_timing: pixel-strobe divider, horizontal/vertical counters and
// raw sync/active decode.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   pck              one-CLK-wide pixel strobe (registered)
//   hcount, vcount   current counter position
//   active           position lies inside the visible area
//   hs_window        hcount inside the horizontal sync interval
//   vs_window        vcount inside the vertical sync interval
//   frame_last       position is the last pixel of the frame
module vga_timing
    import pattern_gen_param_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CNT_W    = 10
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             pck,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             active,
    output logic             hs_window,
    output logic             vs_window,
    output logic             frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pck_q, pck_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // Strobe is registered so it is low during reset; with CLK_DIV=1
        // the divider stays at 0 and the strobe is high every cycle.
        pck_d    = (div_d == DIV_LAST);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pck_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q    <= '0;
            pck_q    <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            div_q    <= div_d;
            pck_q    <= pck_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pck        = pck_q;
    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign active     = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    assign hs_window  = (hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST);
    assign vs_window  = (vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST);
    assign frame_last = (hcount_q == H_LAST) && (vcount_q == V_LAST);

endmodule

// File: rtl/pattern_gen_param.sv
// pattern_gen_param: VGA test-pattern generator (bars, grid, gradient,
// checkerboard) with fully parameterised timing.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   MODE                   pattern select, taken at the frame boundary
//   VGA_R/VGA_G/VGA_B      pixel colour, zero outside the active area
//   VGA_HS/VGA_VS          syncs, active level HS_POL/VS_POL
//   VGA_DE                 active video
//   PCK                    one-CLK-wide pixel strobe
//   FRAME_START            high together with the DE of pixel (0,0),
//                          held for that pixel like the other outputs
// All pixel outputs are registered on PCK, one pixel after the counters.
module pattern_gen_param
    import pattern_gen_param_pkg::*;
#(
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CELL_LOG2 = DEF_CELL_LOG2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         MODE,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_DE,
    output logic               PCK,
    output logic               FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_ACTIVE);
    localparam int BAR_W   = H_ACTIVE / 8;
    // Counters are wide enough to index the checker bit even on tiny rasters.
    localparam int CNT_W   = max_int(max_int($clog2(H_TOTAL), $clog2(V_TOTAL)),
                                     CELL_LOG2 + 1);

    localparam logic               HS_ON = (HS_POL != 0);
    localparam logic               VS_ON = (VS_POL != 0);
    localparam logic [COLOR_W-1:0] FULL  = '1;

    logic             pck;
    logic [CNT_W-1:0] hcount, vcount;
    logic             active, hs_window, vs_window, frame_last;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W   (CNT_W)
    ) u_timing (
        .CLK       (CLK),
        .RST       (RST),
        .pck       (pck),
        .hcount    (hcount),
        .vcount    (vcount),
        .active    (active),
        .hs_window (hs_window),
        .vs_window (vs_window),
        .frame_last(frame_last)
    );

    mode_e              mode_q, mode_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;

    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;
    logic [3:0]         bar_idx;
    logic [2:0]         bar_bits;
    logic               white;

    // Pattern for the current counter position.
    always_comb begin
        // Bar index by comparison against constant boundaries; index 8 is
        // the leftover strip when H_ACTIVE is not a multiple of 8.
        bar_idx = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            if (hcount >= CNT_W'(i * BAR_W)) begin
                bar_idx = 4'(i);
            end
        end
        bar_bits = bar_idx[3] ? 3'b000 : bar_rgb(bar_idx[2:0]);
        white    = 1'b0;
        pat_r    = '0;
        pat_g    = '0;
        pat_b    = '0;
        case (mode_q)
            MODE_BARS: begin
                pat_r = bar_bits[2] ? FULL : '0;
                pat_g = bar_bits[1] ? FULL : '0;
                pat_b = bar_bits[0] ? FULL : '0;
            end
            MODE_GRID: begin
                white = (hcount[CELL_LOG2-1:0] == '0) || (vcount[CELL_LOG2-1:0] == '0) ||
                        (hcount == CNT_W'(H_ACTIVE - 1)) || (vcount == CNT_W'(V_ACTIVE - 1));
                pat_r = white ? FULL : '0;
                pat_g = pat_r;
                pat_b = pat_r;
            end
            MODE_GRAD: begin
                pat_r = hcount[HW-1 -: COLOR_W];
                pat_g = pat_r;
                pat_b = pat_r;
            end
            default: begin
                white = ~(hcount[CELL_LOG2] ^ vcount[CELL_LOG2]);
                pat_r = white ? FULL : '0;
                pat_g = pat_r;
                pat_b = pat_r;
            end
        endcase
    end

    // Output registers: load only on the strobe, otherwise hold.
    always_comb begin
        mode_d = mode_q;
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        de_d   = de_q;
        fs_d   = fs_q;
        if (pck) begin
            r_d  = active ? pat_r : '0;
            g_d  = active ? pat_g : '0;
            b_d  = active ? pat_b : '0;
            de_d = active;
            hs_d = hs_window ? HS_ON : ~HS_ON;
            vs_d = vs_window ? VS_ON : ~VS_ON;
            fs_d = active && (hcount == '0) && (vcount == '0);
            // New mode takes effect from pixel (0,0) of the next frame.
            if (frame_last) begin
                mode_d = mode_e'(MODE);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= MODE_BARS;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_DE      = de_q;
    assign FRAME_START = fs_q;
    assign PCK         = pck;

endmodule

// File: tb/tb_pattern_gen_param.sv
// Bench for pattern_gen_param.
// u0: small raster 20+2+3+3 x 10+1+2+2, CLK_DIV=2, HS active low,
//     VS active high, 4-pixel cells; 28x15 = 420 pixels per frame.
// u1: 640-wide raster, 5 lines, CLK_DIV=1, COLOR_W=8, MODE fixed at 2.
// Packed u0 observation: {R,G,B,DE,HS,VS,FRAME_START} = 16 bits.
module tb_pattern_gen_param;

    localparam int H_TOT0 = 28;
    localparam int F_PIX0 = 28 * 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] MODE0, MODE1;

    logic [3:0] r0, g0, b0;
    logic       hs0, vs0, de0, pck0, fs0;
    logic [7:0] r1, g1, b1;
    logic       hs1, vs1, de1, pck1, fs1;

    always #5 CLK = ~CLK;

    pattern_gen_param #(
        .COLOR_W(4), .CLK_DIV(2),
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(1), .CELL_LOG2(2)
    ) u0 (
        .CLK(CLK), .RST(RST), .MODE(MODE0),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
        .VGA_HS(hs0), .VGA_VS(vs0), .VGA_DE(de0),
        .PCK(pck0), .FRAME_START(fs0)
    );

    pattern_gen_param #(
        .COLOR_W(8), .CLK_DIV(1),
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CELL_LOG2(5)
    ) u1 (
        .CLK(CLK), .RST(RST), .MODE(MODE1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .VGA_HS(hs1), .VGA_VS(vs1), .VGA_DE(de1),
        .PCK(pck1), .FRAME_START(fs1)
    );

    typedef struct {
        logic [1:0]  mode;
        int          h;
        int          v;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   pos;

    function automatic vec_t mk(input logic [1:0] m, input int h, input int v,
                                input logic [15:0] e);
        vec_t t;
        t.mode = m; t.h = h; t.v = v; t.exp = e;
        return t;
    endfunction

    function automatic logic [15:0] obs0();
        return {r0, g0, b0, de0, hs0, vs0, fs0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Advance to the next u0 strobe; afterwards outputs show pixel 'pos'.
    task automatic next_pix(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 8) begin
            if (pck0) begin
                @(posedge CLK); #1;
                ok = 1'b1;
            end else begin
                @(posedge CLK); #1;
                n++;
            end
        end
        if (ok) pos = (pos + 1) % F_PIX0;
    endtask

    task automatic goto_px(input int h, input int v);
        int target, steps;
        bit ok;
        target = v * H_TOT0 + h;
        steps  = 0;
        do begin
            next_pix(ok);
            steps++;
        end while (ok && pos != target && steps < 2 * F_PIX0 + 4);
        if (!ok || pos != target) timeout($sformatf("goto_%0d_%0d", h, v));
    endtask

    initial begin
        int   hi0, hi1, cnt;
        bit   found, prev, ok;
        logic [1:0] cur_mode;

        RST   = 1'b1;
        MODE0 = 2'd0;
        MODE1 = 2'd2;
        pos   = -1;

        // Modes 0..3 vectors, sorted so each mode run moves forward in the frame.
        vecs.push_back(mk(2'd0,  0,  0, 16'hFFFD));
        vecs.push_back(mk(2'd0,  1,  0, 16'hFFFC));
        vecs.push_back(mk(2'd0,  2,  0, 16'hFF0C));
        vecs.push_back(mk(2'd0,  5,  0, 16'h0FFC));
        vecs.push_back(mk(2'd0,  7,  0, 16'h0F0C));
        vecs.push_back(mk(2'd0,  9,  0, 16'hF0FC));
        vecs.push_back(mk(2'd0, 10,  0, 16'hF00C));
        vecs.push_back(mk(2'd0, 13,  0, 16'h00FC));
        vecs.push_back(mk(2'd0, 15,  0, 16'h000C));
        vecs.push_back(mk(2'd0, 16,  0, 16'h000C));
        vecs.push_back(mk(2'd0, 19,  0, 16'h000C));
        vecs.push_back(mk(2'd0, 20,  0, 16'h0004));
        vecs.push_back(mk(2'd0, 22,  0, 16'h0000));
        vecs.push_back(mk(2'd0, 24,  0, 16'h0000));
        vecs.push_back(mk(2'd0, 25,  0, 16'h0004));
        vecs.push_back(mk(2'd0,  3,  9, 16'hFF0C));
        vecs.push_back(mk(2'd0, 19,  9, 16'h000C));
        vecs.push_back(mk(2'd0,  3, 11, 16'h0006));
        vecs.push_back(mk(2'd0,  0, 12, 16'h0006));
        vecs.push_back(mk(2'd0,  0, 13, 16'h0004));
        vecs.push_back(mk(2'd1,  0,  1, 16'hFFFC));
        vecs.push_back(mk(2'd1,  1,  1, 16'h000C));
        vecs.push_back(mk(2'd1, 18,  1, 16'h000C));
        vecs.push_back(mk(2'd1, 19,  1, 16'hFFFC));
        vecs.push_back(mk(2'd1, 20,  1, 16'h0004));
        vecs.push_back(mk(2'd1,  1,  4, 16'hFFFC));
        vecs.push_back(mk(2'd1,  6,  5, 16'h000C));
        vecs.push_back(mk(2'd1,  5,  9, 16'hFFFC));
        vecs.push_back(mk(2'd2,  0,  2, 16'h000C));
        vecs.push_back(mk(2'd2,  3,  2, 16'h111C));
        vecs.push_back(mk(2'd2, 12,  2, 16'h666C));
        vecs.push_back(mk(2'd2, 19,  2, 16'h999C));
        vecs.push_back(mk(2'd3,  4,  0, 16'h000C));
        vecs.push_back(mk(2'd3, 20,  0, 16'h0004));
        vecs.push_back(mk(2'd3,  1,  1, 16'hFFFC));
        vecs.push_back(mk(2'd3,  4,  4, 16'hFFFC));
        vecs.push_back(mk(2'd3,  0,  5, 16'h000C));
        vecs.push_back(mk(2'd3,  7,  6, 16'hFFFC));
        vecs.push_back(mk(2'd3,  3,  7, 16'h000C));

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out0", obs0(), 16'h0004);
        check("rst_pck0", pck0, 0);
        check("rst_out1", {r1, g1, b1, de1, hs1, vs1, fs1, pck1}, 32'h0000000C);

        // Strobe rates after release.
        RST = 1'b0;
        hi0 = 0;
        hi1 = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            hi0 += pck0;
            hi1 += pck1;
        end
        check("pck0_rate", hi0, 10);
        check("pck1_const", hi1, 20);

        // FRAME_START period, then align the pixel tracker on it.
        found = 1'b0;
        prev  = fs0;
        cnt   = 0;
        while (!found && cnt < 2000) begin
            @(posedge CLK); #1;
            cnt++;
            if (fs0 && !prev) found = 1'b1;
            prev = fs0;
        end
        if (!found) timeout("fs0_first");
        found = 1'b0;
        cnt   = 0;
        while (!found && cnt < 2000) begin
            @(posedge CLK); #1;
            cnt++;
            if (fs0 && !prev) found = 1'b1;
            prev = fs0;
        end
        check("fs0_period", cnt, 840);
        pos = 0;

        // Table-driven pixels.
        cur_mode = 2'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].mode != cur_mode) begin
                MODE0    = vecs[i].mode;
                cur_mode = vecs[i].mode;
                goto_px(H_TOT0 - 1, 14);
            end
            goto_px(vecs[i].h, vecs[i].v);
            check($sformatf("vec%0d_m%0d_%0d_%0d", i, vecs[i].mode, vecs[i].h, vecs[i].v),
                  obs0(), vecs[i].exp);
        end

        // Mid-frame mode change only shows in the following frame.
        MODE0 = 2'd0;
        goto_px(H_TOT0 - 1, 14);
        goto_px(0, 5);
        MODE0 = 2'd3;
        goto_px(4, 5);
        check("midframe_still_bars", obs0(), 16'h0FFC);
        goto_px(4, 0);
        check("next_frame_checker_black", obs0(), 16'h000C);
        goto_px(4, 4);
        check("next_frame_checker_white", obs0(), 16'hFFFC);

        // Reset mid-frame: abandon frame, restart at (0,0) in mode 0.
        goto_px(3, 5);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("midrst_out0", obs0(), 16'h0004);
        check("midrst_pck0", pck0, 0);
        RST = 1'b0;
        pos = -1;
        next_pix(ok);
        if (!ok) timeout("midrst_first_strobe");
        check("midrst_first_px", obs0(), 16'hFFFD);
        goto_px(4, 0);
        check("midrst_mode0", obs0(), 16'h0FFC);

        // u1 gradient: second frame after reset uses the latched MODE=2.
        for (int k = 0; k < 2; k++) begin
            found = 1'b0;
            prev  = fs1;
            cnt   = 0;
            while (!found && cnt < 9000) begin
                @(posedge CLK); #1;
                cnt++;
                if (fs1 && !prev) found = 1'b1;
                prev = fs1;
            end
            if (!found) timeout($sformatf("fs1_edge%0d", k));
        end
        repeat (512) @(posedge CLK);
        #1;
        check("grad_512", {r1, g1, b1, de1}, {8'h80, 8'h80, 8'h80, 1'b1});
        repeat (127) @(posedge CLK);
        #1;
        check("grad_639", {r1, g1, b1, de1}, {8'h9F, 8'h9F, 8'h9F, 1'b1});
        @(posedge CLK);
        #1;
        check("grad_640_blank", {r1, g1, b1, de1}, 25'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
